// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//
// Control sequencer for the shared multiply/divide datapath. A one-cycle
// start pulse from execute moves the FSM through LOAD, then a fixed number
// of iteration steps (radix-4 Booth multiply or non-restoring divide),
// then a single DONE cycle that pulses data_resultRDY. A zero divisor seen
// in LOAD skips the iterations and reports data_exception in DONE.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   ctrl_MULT/ctrl_DIV  start pulses; MULT wins if both arrive together
//   divisor_zero        datapath flag sampled in LOAD for divides
//   booth_bits          multiplier window {q[1], q[0], q[-1]} during MULT
//   rem_neg             partial remainder sign during DIV
//   load                datapath latches operands (LOAD state)
//   shift_en            one iteration step (MULT or DIV state)
//   booth_op            {sub, x2, en} add/subtract M or 2M
//   div_sub             subtract divisor this step when 1, add when 0
//   busy                pipeline stall while LOAD/MULT/DIV
//   data_resultRDY      one-cycle result-valid pulse (DONE state)
//   data_exception      divide-by-zero, valid with data_resultRDY
//   count               iterations completed, cleared in LOAD, saturating

module multdiv_sequencer #(
    parameter int MULT_STEPS = 16,
    parameter int DIV_STEPS  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic [2:0]       booth_bits,
    input  logic             rem_neg,
    output logic             load,
    output logic             shift_en,
    output logic [2:0]       booth_op,
    output logic             div_sub,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    state_t           state_q, state_d;
    logic             op_div_q, op_div_d;
    logic             exc_q, exc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;

    // Moore outputs are registered from the next-state decode so they line
    // up exactly with the state they describe.
    logic load_q, busy_q, rdy_q, exc_out_q, mult_act_q, div_act_q;

    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

    // Next-state logic. IDLE and DONE both accept a new start so a result
    // cycle can be followed immediately by the next LOAD.
    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        exc_d    = exc_q;
        count_d  = count_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ctrl_MULT) begin
                    state_d  = S_LOAD;
                    op_div_d = 1'b0;
                end else if (ctrl_DIV) begin
                    state_d  = S_LOAD;
                    op_div_d = 1'b1;
                end
            end
            S_LOAD: begin
                count_d = '0;
                exc_d   = 1'b0;
                if (!op_div_q) begin
                    state_d = S_MULT;
                end else if (divisor_zero) begin
                    state_d = S_DONE;
                    exc_d   = 1'b1;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_MULT: begin
                count_d = count_inc;
                if (count_q == MULT_LAST) state_d = S_DONE;
            end
            S_DIV: begin
                count_d = count_inc;
                if (count_q == DIV_LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_div_q   <= 1'b0;
            exc_q      <= 1'b0;
            count_q    <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            exc_out_q  <= 1'b0;
            mult_act_q <= 1'b0;
            div_act_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_div_q   <= op_div_d;
            exc_q      <= exc_d;
            count_q    <= count_d;
            load_q     <= (state_d == S_LOAD);
            busy_q     <= (state_d == S_LOAD) || (state_d == S_MULT) || (state_d == S_DIV);
            rdy_q      <= (state_d == S_DONE);
            exc_out_q  <= (state_d == S_DONE) && exc_d;
            mult_act_q <= (state_d == S_MULT);
            div_act_q  <= (state_d == S_DIV);
        end
    end

    // Booth recoding of the window {q1,q0,q-1}: 011 means +2M, 100 means -2M,
    // mixed patterns mean +/-M, and the uniform patterns mean no add.
    logic [2:0] booth_dec;
    always_comb begin
        booth_dec = 3'b000;
        unique case (booth_bits)
            3'b000, 3'b111: booth_dec = 3'b000;
            3'b001, 3'b010: booth_dec = 3'b001;
            3'b011:         booth_dec = 3'b011;
            3'b100:         booth_dec = 3'b111;
            3'b101, 3'b110: booth_dec = 3'b101;
            default:        booth_dec = 3'b000;
        endcase
    end

    assign load           = load_q;
    assign busy           = busy_q;
    assign shift_en       = mult_act_q | div_act_q;
    assign booth_op       = mult_act_q ? booth_dec : 3'b000;
    assign div_sub        = div_act_q & ~rem_neg;
    assign data_resultRDY = rdy_q;
    assign data_exception = exc_out_q;
    assign count          = count_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer. A transaction-level model
// predicts the schedule of each accepted operation from its issue cycle;
// a scoreboard queue holds the expected result pulses.

module tb_multdiv_sequencer;

    logic       clock;
    logic       reset;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       divisor_zero;
    logic [2:0] booth_bits;
    logic       rem_neg;
    logic       load;
    logic       shift_en;
    logic [2:0] booth_op;
    logic       div_sub;
    logic       busy;
    logic       data_resultRDY;
    logic       data_exception;
    logic [5:0] count;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .divisor_zero   (divisor_zero),
        .booth_bits     (booth_bits),
        .rem_neg        (rem_neg),
        .load           (load),
        .shift_en       (shift_en),
        .booth_op       (booth_op),
        .div_sub        (div_sub),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .count          (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic in_reset;

    always @(posedge clock) cyc <= cyc + 1;

    // One accepted operation: issue cycle, kind and zero-divisor flag.
    typedef struct {
        logic valid;
        int   st;
        logic dv;
        logic zr;
    } txn_t;

    typedef struct {
        int   cyc;
        logic exc;
    } res_t;

    txn_t cur, prev;
    res_t sb[$];

    function automatic int steps_of(input txn_t t);
        if (t.zr) return 0;
        return t.dv ? 32 : 16;
    endfunction

    function automatic int done_of(input txn_t t);
        return t.st + 2 + steps_of(t);
    endfunction

    function automatic logic is_free(input int n);
        return !cur.valid || n >= done_of(cur);
    endfunction

    // Booth digit value -2*q1 + q0 + q-1 mapped to {sub, x2, en}.
    function automatic logic [2:0] booth_ref(input logic [2:0] bb);
        int d;
        d = -2 * int'(bb[2]) + int'(bb[1]) + int'(bb[0]);
        return {d < 0, (d == 2) || (d == -2), d != 0};
    endfunction

    // Expected {busy, load, shift_en, booth_op, div_sub, rdy, exc} for cycle n.
    function automatic logic [8:0] exp_vec(input txn_t t, input int n,
                                            input logic [2:0] bb, input logic rn);
        logic       ld, wk, rdy;
        logic [2:0] bo;
        logic       ds;
        if (!t.valid) return 9'd0;
        ld  = (n == t.st + 1);
        wk  = (n >= t.st + 2) && (n < t.st + 2 + steps_of(t));
        rdy = (n == done_of(t));
        bo  = (wk && !t.dv) ? booth_ref(bb) : 3'b000;
        ds  = (wk && t.dv) ? ~rn : 1'b0;
        return {ld | wk, ld, wk, bo, ds, rdy, rdy & t.zr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic check_count(input txn_t t, input int n);
        if (!t.valid) return;
        if (n >= t.st + 2 && n < t.st + 2 + steps_of(t))
            check("count_step", 32'(count), 32'(n - (t.st + 2)));
        else if (n == done_of(t))
            check("count_done", 32'(count), 32'(steps_of(t)));
    endtask

    // Per-cycle comparison of the control outputs against the model.
    task automatic checkOutput();
        logic [8:0] act, expv;
        act = {busy, load, shift_en, booth_op, div_sub, data_resultRDY, data_exception};
        if (in_reset) begin
            check("reset_outputs", 32'(act), 32'd0);
            check("reset_count", 32'(count), 32'd0);
        end else begin
            expv = exp_vec(cur, cyc, booth_bits, rem_neg) | exp_vec(prev, cyc, booth_bits, rem_neg);
            check("ctrl_outputs", 32'(act), 32'(expv));
            check_count(cur, cyc);
            check_count(prev, cyc);
        end
    endtask

    // Monitor: compare outputs every cycle and pop the scoreboard on each result.
    always @(negedge clock) begin
        checkOutput();
        if (!in_reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = sb.pop_front();
                check("result_cycle", 32'(cyc), 32'(r.cyc));
                check("result_exception", 32'(data_exception), 32'(r.exc));
            end
        end
    end

    // Drive one cycle of inputs, record accepted starts, then advance.
    task automatic applyStimulus(input logic m, input logic d, input logic zr,
                                 input logic [2:0] bb, input logic rn);
        txn_t t;
        ctrl_MULT    = m;
        ctrl_DIV     = d;
        booth_bits   = bb;
        rem_neg      = rn;
        divisor_zero = 1'($urandom);
        if (cur.valid && cur.dv && cyc == cur.st + 1) divisor_zero = cur.zr;
        if ((m || d) && !in_reset && is_free(cyc)) begin
            t.valid = 1'b1;
            t.st    = cyc;
            t.dv    = !m;
            t.zr    = !m && zr;
            prev    = cur;
            cur     = t;
            sb.push_back('{done_of(t), t.zr});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 3'($urandom), 1'($urandom));
    endtask

    task automatic clear_model();
        cur.valid  = 1'b0;
        prev.valid = 1'b0;
        sb.delete();
    endtask

    initial begin
        in_reset     = 1'b1;
        reset        = 1'b0;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        divisor_zero = 1'b0;
        booth_bits   = 3'b000;
        rem_neg      = 1'b0;
        clear_model();
        #1;
        check("por_outputs", 32'({busy, load, shift_en, booth_op, div_sub, data_resultRDY, data_exception}), 32'd0);
        @(posedge clock);
        #1;
        idle(2);
        reset    = 1'b1;
        in_reset = 1'b0;
        idle(2);

        // Multiply with a constant +2M window.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'b011, 1'b0);

        // Booth decode sweep over all windows during a multiply.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'(i % 8), 1'b0);

        // Divide with alternating remainder sign, then zero-divisor abort.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 36; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'($urandom), 1'(i % 2));
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(4);

        // Both starts together run a multiply; a DIV pulse in cycle 5 is dropped.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b101, 1'b0);
        for (int i = 1; i <= 20; i++)
            applyStimulus(1'b0, i == 5, 1'b0, 3'($urandom), 1'($urandom));

        // Back-to-back: divide issued in the DONE cycle of a multiply.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b110, 1'b0);
        for (int i = 1; i <= 17; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'($urandom), 1'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, 3'($urandom), 1'($urandom));
        idle(36);

        // Reset asserted mid-divide: outputs drop without a clock edge.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        idle(10);
        #1;
        reset    = 1'b0;
        in_reset = 1'b1;
        clear_model();
        #1;
        check("async_reset_outputs", 32'({busy, load, shift_en, booth_op, div_sub, data_resultRDY, data_exception}), 32'd0);
        check("async_reset_count", 32'(count), 32'd0);
        @(posedge clock);
        #1;
        idle(2);
        reset    = 1'b1;
        in_reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
        idle(40);

        // Randomised traffic, including ignored and back-to-back starts.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            applyStimulus(r == 0 || r == 3, r == 1 || r == 2 || r == 3,
                          $urandom_range(0, 3) == 0, 3'($urandom), 1'($urandom));
        end
        idle(40);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
